// File: rtl/systolic_result_drain_pkg.sv
// Shared constants and types for the systolic array result drain stage.
// The 3x3 array yields nine elements, streamed with a 4-bit index.
package systolic_result_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  localparam int N                  = 3;
  localparam int NUM_ELEM           = N * N;
  localparam int IDX_W              = 4;
  localparam int CNT_W              = 4;
  localparam int DEF_COMPUTE_CYCLES = 3 * N - 2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

endpackage

// File: rtl/result_buffer_9x.sv
// Nine-entry capture register for the array's C outputs plus the read mux.
// Holds its contents between captures so the array can be reused during a drain.
module result_buffer_9x
  import systolic_result_drain_pkg::*;
#(
  parameter int WIDTH_SUM = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          capture,
  input  logic [NUM_ELEM*WIDTH_SUM-1:0] c_in,
  input  logic [IDX_W-1:0]              rd_idx,
  output logic [WIDTH_SUM-1:0]          rd_data
);

  logic [WIDTH_SUM-1:0] mem_q [NUM_ELEM];
  logic [WIDTH_SUM-1:0] mem_d [NUM_ELEM];

  always_comb begin
    for (int i = 0; i < NUM_ELEM; i++) begin
      mem_d[i] = capture ? c_in[i*WIDTH_SUM +: WIDTH_SUM] : mem_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ELEM; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ELEM; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Out-of-range indices read as zero rather than aliasing another entry.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      if (rd_idx == IDX_W'(i)) rd_data = mem_q[i];
    end
  end

endmodule

// File: rtl/systolic_result_drain.sv
// Runs the 3x3 systolic array for a fixed number of enabled cycles, snapshots
// its nine results and overflow flag, then streams them out row-major.
module systolic_result_drain
  import systolic_result_drain_pkg::*;
#(
  parameter int WIDTH_SUM      = 8,
  parameter int COMPUTE_CYCLES = DEF_COMPUTE_CYCLES
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          START,
  input  logic [NUM_ELEM*WIDTH_SUM-1:0] C_IN,
  input  logic                          MULTI_OVER_IN,
  output logic                          ARRAY_EN,
  output logic                          BUSY,
  output logic [WIDTH_SUM-1:0]          OUT_DATA,
  output logic [IDX_W-1:0]              OUT_INDEX,
  output logic                          OUT_VALID,
  input  logic                          OUT_READY,
  output logic                          OUT_LAST,
  output logic                          OUT_OVER,
  output logic                          DONE,
  output logic [1:0]                    DBG_STATE
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COMPUTE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             over_q, over_d;
  logic             done_q, done_d;
  logic             capture;

  // Output handshake: an element transfers on every rising edge where
  // OUT_VALID and OUT_READY are both high. OUT_VALID never depends on
  // OUT_READY, and data/index/last hold steady until the transfer happens.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    over_d  = over_q;
    done_d  = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_COMPUTE;
          cnt_d   = '0;
        end
      end
      ST_COMPUTE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          capture = 1'b1;
          over_d  = MULTI_OVER_IN;
          idx_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (OUT_READY) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      over_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      over_q  <= over_d;
      done_q  <= done_d;
    end
  end

  result_buffer_9x #(
    .WIDTH_SUM(WIDTH_SUM)
  ) u_buf (
    .clk     (CLK),
    .rst     (RST),
    .capture (capture),
    .c_in    (C_IN),
    .rd_idx  (idx_q),
    .rd_data (OUT_DATA)
  );

  assign ARRAY_EN  = (state_q == ST_COMPUTE);
  assign BUSY      = (state_q != ST_IDLE);
  assign OUT_VALID = (state_q == ST_DRAIN);
  assign OUT_LAST  = (state_q == ST_DRAIN) && (idx_q == LAST_IDX);
  assign OUT_INDEX = idx_q;
  assign OUT_OVER  = over_q;
  assign DONE      = done_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Bench for systolic_result_drain: a queue-based transaction model predicts
// every output each cycle; runs cover basic, backpressure, overflow, START and reset cases.
module tb_systolic_result_drain;

  localparam int W  = 8;
  localparam int CC = 7;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           over_in = 1'b0;
  logic           out_ready = 1'b0;
  logic [9*W-1:0] c_in = '0;
  logic           array_en, busy, out_valid, out_last, out_over, done;
  logic [W-1:0]   out_data;
  logic [3:0]     out_index;
  logic [1:0]     dbg_state;

  always #5 clk = ~clk;

  systolic_result_drain #(
    .WIDTH_SUM(W),
    .COMPUTE_CYCLES(CC)
  ) dut (
    .CLK           (clk),
    .RST           (rst),
    .START         (start),
    .C_IN          (c_in),
    .MULTI_OVER_IN (over_in),
    .ARRAY_EN      (array_en),
    .BUSY          (busy),
    .OUT_DATA      (out_data),
    .OUT_INDEX     (out_index),
    .OUT_VALID     (out_valid),
    .OUT_READY     (out_ready),
    .OUT_LAST      (out_last),
    .OUT_OVER      (out_over),
    .DONE          (done),
    .DBG_STATE     (dbg_state)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A run is "compute cycles left" followed by a queue of captured elements
  // that empties one entry per accepted transfer.
  int           m_en_left = 0;
  logic [W-1:0] m_q[$];
  int           m_idx = 0;
  logic         m_over = 1'b0;
  logic         m_done = 1'b0;
  logic         m_nd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_en_left = 0;
      m_q.delete();
      m_idx  = 0;
      m_over = 1'b0;
      m_done = 1'b0;
    end else begin
      m_nd = 1'b0;
      if (m_en_left > 0) begin
        m_en_left--;
        if (m_en_left == 0) begin
          m_q.delete();
          for (int i = 0; i < 9; i++) m_q.push_back(c_in[i*W +: W]);
          m_over = over_in;
          m_idx  = 0;
        end
      end else if (m_q.size() > 0) begin
        if (out_ready) begin
          void'(m_q.pop_front());
          m_idx++;
          if (m_q.size() == 0) m_nd = 1'b1;
        end
      end else if (start) begin
        m_en_left = CC;
      end
      m_done = m_nd;
    end
  end

  // ---------------- per-cycle compare + transfer log ----------------
  int           en_cnt = 0;
  int           done_cnt = 0;
  logic [W-1:0] log_data[$];
  int           log_idx[$];
  logic         log_over[$];

  always @(negedge clk) begin
    check("array_en", array_en, m_en_left > 0);
    check("busy", busy, (m_en_left > 0) || (m_q.size() > 0));
    check("out_valid", out_valid, m_q.size() > 0);
    check("out_over", out_over, m_over);
    check("done", done, m_done);
    if (m_q.size() > 0) begin
      check("out_data", out_data, m_q[0]);
      check("out_index", out_index, m_idx);
      check("out_last", out_last, m_q.size() == 1);
    end else begin
      check("out_last_idle", out_last, 0);
    end
    if (array_en) en_cnt++;
    if (done) done_cnt++;
    if (out_valid && out_ready && !rst) begin
      log_data.push_back(out_data);
      log_idx.push_back(int'(out_index));
      log_over.push_back(out_over);
    end
  end

  // ---------------- drivers ----------------
  int ready_mode = 0;
  int pc = 0;

  always @(posedge clk) begin
    #1;
    pc++;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (pc % 3 == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic scramble_arm = 1'b0;
  logic scramble = 1'b0;

  always @(negedge clk) if (scramble_arm && out_valid) scramble = 1'b1;

  always @(posedge clk) begin
    #1;
    if (scramble) begin
      c_in    = 72'({$urandom(), $urandom(), $urandom()});
      over_in = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- stimulus / scoreboard ----------------
  int           a[9];
  int           b[9];
  logic [W-1:0] exp_q[$];
  int           lit[9] = '{30, 36, 42, 66, 81, 96, 102, 126, 150};

  // The array stub: C = A*B, truncated to the element width.
  task automatic load_mats();
    c_in = '0;
    exp_q.delete();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        int s;
        s = 0;
        for (int k = 0; k < 3; k++) s += a[r*3+k] * b[k*3+c];
        c_in[(3*r+c)*W +: W] = W'(s);
        exp_q.push_back(W'(s));
      end
    end
  endtask

  task automatic rand_mats();
    for (int i = 0; i < 9; i++) begin
      a[i] = $urandom_range(0, 255);
      b[i] = $urandom_range(0, 255);
    end
    load_mats();
  endtask

  task automatic clear_logs();
    log_data.delete();
    log_idx.delete();
    log_over.delete();
    en_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic run_check(input string tag, input logic exp_over);
    bit seen;
    clear_logs();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(400, seen);
    check({tag, "_timeout"}, seen, 1);
    @(negedge clk);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_en_cycles"}, en_cnt, CC);
    check({tag, "_xfer_count"}, log_data.size(), 9);
    for (int i = 0; i < log_data.size() && i < 9; i++) begin
      check({tag, "_data"}, log_data[i], exp_q[i]);
      check({tag, "_index"}, log_idx[i], i);
      check({tag, "_over"}, log_over[i], exp_over);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_array_en"}, array_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_over"}, out_over, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_index"}, out_index, 0);
  endtask

  initial begin
    bit seen;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("init");
    rst = 1'b0;

    // Basic run: A = B = [1..9], pinned against hand-computed products.
    for (int i = 0; i < 9; i++) begin
      a[i] = i + 1;
      b[i] = i + 1;
    end
    load_mats();
    over_in    = 1'b0;
    ready_mode = 0;
    run_check("basic", 1'b0);
    for (int i = 0; i < 9; i++) begin
      check("basic_literal", (i < log_data.size()) ? 32'(log_data[i]) : 32'hFFFF, lit[i]);
    end

    // Backpressure with the 1,0,0 ready pattern.
    ready_mode = 1;
    run_check("bp", 1'b0);
    for (int i = 0; i < 9; i++) begin
      check("bp_literal", (i < log_data.size()) ? 32'(log_data[i]) : 32'hFFFF, lit[i]);
    end

    // Overflow captured, then inputs scrambled for the whole drain.
    rand_mats();
    over_in      = 1'b1;
    ready_mode   = 2;
    scramble_arm = 1'b1;
    run_check("ovf", 1'b1);
    scramble_arm = 1'b0;
    scramble     = 1'b0;

    // START held through a whole run including the final transfer.
    rand_mats();
    over_in    = 1'b0;
    ready_mode = 2;
    clear_logs();
    @(posedge clk); #1;
    start = 1'b1;
    wait_done(400, seen);
    start = 1'b0;
    check("ign_timeout", seen, 1);
    repeat (20) @(negedge clk);
    check("ign_en_cycles", en_cnt, CC);
    check("ign_runs", done_cnt, 1);
    check("ign_xfer_count", log_data.size(), 9);
    run_check("ign_second", 1'b0);

    // Reset in the middle of a drain, right after index 4 is accepted.
    rand_mats();
    over_in    = 1'b1;
    ready_mode = 0;
    clear_logs();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_index == 4'd4) seen = 1'b1;
    end
    check("mid_rst_reach_idx4", seen, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_rst_no_done", done_cnt, 0);
    check("mid_rst_accepted", log_data.size(), 5);
    run_check("after_rst", 1'b1);

    // Randomized runs.
    for (int n = 0; n < 8; n++) begin
      rand_mats();
      over_in    = 1'($urandom_range(0, 1));
      ready_mode = $urandom_range(0, 2);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      run_check("rand", over_in);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
